// File: rtl/mem_responder.sv
// Word-addressed 32-bit memory behind a valid/ready request/response port,
// with a programmable number of wait states and out-of-range error reporting.
module mem_responder #(
  parameter int DEPTH       = 64,
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_next;
  logic [3:0]        wait_cnt;
  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              enter_resp;
  logic              acc_write;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic              acc_in_range;
  logic [IDX_W-1:0]  acc_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (wait_cnt <= 4'd1) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // With zero wait states the access happens on the accept edge, so the
  // request is taken straight from the port instead of the latched copy.
  always_comb begin
    acc_write    = (state == IDLE) ? req_write : lat_write;
    acc_addr     = (state == IDLE) ? req_addr  : lat_addr;
    acc_wdata    = (state == IDLE) ? req_wdata : lat_wdata;
    acc_in_range = (32'(acc_addr) < 32'(DEPTH));
    acc_idx      = acc_addr[IDX_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= 4'd0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= 32'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        wait_cnt  <= 4'(WAIT_CYCLES);
      end else if (state == WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      if (enter_resp) begin
        rsp_rdata <= (!acc_write && acc_in_range) ? mem[acc_idx] : 32'd0;
        rsp_err   <= !acc_in_range;
      end else if (rsp_valid && rsp_ready) begin
        rsp_rdata <= 32'd0;
        rsp_err   <= 1'b0;
      end
    end
  end

  // The array is never reset; rst_n only blocks a write on an edge seen while held in reset.
  always_ff @(posedge clk) begin
    if (rst_n && enter_resp && acc_write && acc_in_range)
      mem[acc_idx] <= acc_wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances with 1, 0 and 3 wait
// states; drivers queue expected responses, a negedge monitor checks them.
module tb_mem_responder;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid [N];
  logic        req_ready [N];
  logic        req_write [N];
  logic [11:0] req_addr  [N];
  logic [31:0] req_wdata [N];
  logic        rsp_valid [N];
  logic        rsp_ready [N];
  logic [31:0] rsp_rdata [N];
  logic        rsp_err   [N];

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(64), .ADDR_W(12), .WAIT_CYCLES(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  mem_responder #(.DEPTH(64), .ADDR_W(12), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  mem_responder #(.DEPTH(64), .ADDR_W(12), .WAIT_CYCLES(3)) dut_w3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write(req_write[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
  );

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   acc_cyc [N];
  bit   seen    [N];
  bit   was_hs  [N];
  // Accept-to-rsp_valid latency in clocks for 1, 0 and 3 wait states.
  int   lat_tab [N] = '{2, 1, 4};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int id, input bit wr, input logic [11:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata,
                               input bit exp_err);
    exp_t e;
    bit   got;
    e.id = id; e.rdata = exp_rdata; e.err = exp_err; e.lat = lat_tab[id];
    sb_q.push_back(e);
    got = 1'b0;
    @(posedge clk); #1;
    req_valid[id] = 1'b1;
    req_write[id] = wr;
    req_addr[id]  = addr;
    req_wdata[id] = wdata;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: instance %0d never raised req_ready (required 1)", id);
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    req_write[id] = 1'bx;
    req_addr[id]  = 'x;
    req_wdata[id] = 'x;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (sb_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain_timeout: %0d responses outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Monitor: compares every presented response against the queue head.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (was_hs[i]) begin
        checkOutput($sformatf("post_rsp_rdata%0d", i), rsp_rdata[i], 32'd0);
        checkOutput($sformatf("post_rsp_err%0d", i), 32'(rsp_err[i]), 32'd0);
        checkOutput($sformatf("post_rsp_valid%0d", i), 32'(rsp_valid[i]), 32'd0);
        was_hs[i] = 1'b0;
      end
      if (req_valid[i] && req_ready[i]) acc_cyc[i] = cyc;
      if (rsp_valid[i]) begin
        if (sb_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_rsp: instance %0d rsp_valid=1, required 0", i);
        end else begin
          checkOutput("rsp_instance", 32'(i), 32'(sb_q[0].id));
          checkOutput($sformatf("rsp_rdata%0d", i), rsp_rdata[i], sb_q[0].rdata);
          checkOutput($sformatf("rsp_err%0d", i), 32'(rsp_err[i]), 32'(sb_q[0].err));
          if (!seen[i]) begin
            seen[i] = 1'b1;
            checkOutput($sformatf("latency%0d", i), 32'(cyc - acc_cyc[i]), 32'(sb_q[0].lat));
          end
          if (rsp_ready[i]) begin
            void'(sb_q.pop_front());
            seen[i]   = 1'b0;
            was_hs[i] = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0, c1, c2;
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = 1'b0;
      req_write[i] = 1'b0;
      req_addr[i]  = '0;
      req_wdata[i] = '0;
      rsp_ready[i] = 1'b1;
      acc_cyc[i]   = 0;
      seen[i]      = 1'b0;
      was_hs[i]    = 1'b0;
    end
    repeat (3) @(negedge clk);
    checkOutput("reset_req_ready", 32'(req_ready[0]), 32'd1);
    checkOutput("reset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    checkOutput("reset_rsp_rdata", rsp_rdata[0], 32'd0);
    checkOutput("reset_rsp_err", 32'(rsp_err[0]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Write then read back, one wait state.
    applyStimulus(0, 1'b1, 12'd0, 32'd3, 32'd0, 1'b0);
    applyStimulus(0, 1'b0, 12'd0, 32'hx, 32'd3, 1'b0);
    drain();

    applyStimulus(0, 1'b1, 12'd1, 32'd4, 32'd0, 1'b0);
    applyStimulus(0, 1'b1, 12'd2, 32'h5000_0001, 32'd0, 1'b0);
    applyStimulus(0, 1'b0, 12'd1, 32'hx, 32'd4, 1'b0);
    applyStimulus(0, 1'b0, 12'd2, 32'hx, 32'h5000_0001, 1'b0);
    drain();

    // Out of range: 100 would alias word 36 if the index were truncated.
    applyStimulus(0, 1'b0, 12'd100, 32'hx, 32'd0, 1'b1);
    applyStimulus(0, 1'b1, 12'd36, 32'h24, 32'd0, 1'b0);
    applyStimulus(0, 1'b1, 12'd100, 32'd7, 32'd0, 1'b1);
    applyStimulus(0, 1'b0, 12'd36, 32'hx, 32'h24, 1'b0);
    applyStimulus(0, 1'b0, 12'd4095, 32'hx, 32'd0, 1'b1);
    applyStimulus(0, 1'b0, 12'd63, 32'hx, 32'd0, 1'b0);
    drain();

    // Stalled response with a second request held on the port.
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    applyStimulus(0, 1'b0, 12'd1, 32'hx, 32'd4, 1'b0);
    fork
      applyStimulus(0, 1'b0, 12'd2, 32'hx, 32'h5000_0001, 1'b0);
      begin : stall_branch
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (rsp_valid[0]) break;
        end
        for (int j = 0; j < 5; j++) begin
          checkOutput("stall_req_ready", 32'(req_ready[0]), 32'd0);
          checkOutput("stall_rsp_valid", 32'(rsp_valid[0]), 32'd1);
          @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready[0] = 1'b1;
      end
    join
    drain();

    // Zero wait states: back-to-back reads accepted every two clocks.
    applyStimulus(1, 1'b1, 12'd3, 32'hA, 32'd0, 1'b0);
    applyStimulus(1, 1'b1, 12'd4, 32'hB, 32'd0, 1'b0);
    drain();
    applyStimulus(1, 1'b0, 12'd3, 32'hx, 32'hA, 1'b0);
    c0 = cyc;
    applyStimulus(1, 1'b0, 12'd4, 32'hx, 32'hB, 1'b0);
    c1 = cyc;
    applyStimulus(1, 1'b0, 12'd3, 32'hx, 32'hA, 1'b0);
    c2 = cyc;
    drain();
    checkOutput("b2b_gap1", 32'(c1 - c0), 32'd2);
    checkOutput("b2b_gap2", 32'(c2 - c1), 32'd2);
    applyStimulus(1, 1'b0, 12'd64, 32'hx, 32'd0, 1'b1);
    drain();

    // Three wait states.
    applyStimulus(2, 1'b1, 12'd7, 32'h77, 32'd0, 1'b0);
    applyStimulus(2, 1'b0, 12'd7, 32'hx, 32'h77, 1'b0);
    drain();

    // Reset during the wait state of a write drops that write.
    applyStimulus(0, 1'b1, 12'd5, 32'h11, 32'd0, 1'b0);
    drain();
    @(posedge clk); #1;
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 12'd5;
    req_wdata[0] = 32'd9;
    @(negedge clk);
    checkOutput("abort_req_ready", 32'(req_ready[0]), 32'd1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    checkOutput("abort_req_ready_rst", 32'(req_ready[0]), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(0, 1'b0, 12'd5, 32'hx, 32'h11, 1'b0);
    applyStimulus(0, 1'b0, 12'd1, 32'hx, 32'd4, 1'b0);
    drain();

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
